rank_loader: RTL and testbench

- Upstream feeder for the top-10 selection stage.
- Collects NUM_WORDS PageRank scores arriving serially over a valid/ready stream and packs them into the flat array bus the sorter consumes.
- Sequences the sorter: one-cycle clear pulse, then enable held for exactly SORT_CYCLES cycles, then a done flag while the packed array stays frozen.

---
 rtl/rank_loader.sv | 101 ++++++++++
 tb/tb_rank_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rank_loader.sv
// Serial score loader and sequencer for the top-10 sorter: packs NUM_WORDS scores
// into a flat bus, then issues one clear pulse and SORT_CYCLES enable cycles.
module rank_loader #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WORDS   = 32,
  parameter int SORT_CYCLES = 275
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] array_out,
  output logic                            sort_rst,
  output logic                            sort_en,
  output logic                            busy,
  output logic                            done
);

  localparam int IDX_W = $clog2(NUM_WORDS) + 1;
  localparam int CNT_W = $clog2(SORT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    SORT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] sort_cnt;
  logic             accept;
  logic             last_word;

  // in_ready is registered and only ever high in LOAD, so accept implies LOAD
  assign accept    = in_valid & in_ready;
  assign last_word = in_last | (wr_idx == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_idx    <= '0;
      sort_cnt  <= '0;
      array_out <= '0;
      in_ready  <= 1'b0;
      sort_rst  <= 1'b0;
      sort_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            wr_idx    <= '0;
            array_out <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (wr_idx == IDX_W'(i)) array_out[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            wr_idx <= wr_idx + IDX_W'(1);
            // Drop ready on the final word so nothing past the batch end is taken
            if (last_word) begin
              state    <= CLEAR;
              in_ready <= 1'b0;
              sort_rst <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state    <= SORT;
          sort_rst <= 1'b0;
          sort_en  <= 1'b1;
          sort_cnt <= CNT_W'(SORT_CYCLES - 1);
        end
        SORT: begin
          if (sort_cnt == '0) begin
            state   <= DONE;
            sort_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            sort_cnt <= sort_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_loader.sv
// Bench for rank_loader: table-driven batches plus randomized batches scored
// against a queue-based model of accepted words, and a mid-sort reset sequence.
module tb_rank_loader;

  localparam int DW = 16;
  localparam int NW = 32;
  localparam int SC = 275;
  localparam int AW = DW * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [AW-1:0] array_out;
  logic          sort_rst;
  logic          sort_en;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] words[NW];

  typedef struct {
    int n;
    bit last;
    int gap;
    int vals;
    int ign_start;
    int exp_rst;
    int exp_en;
  } vec_t;

  vec_t tbl[4];

  rank_loader #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SORT_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .array_out(array_out), .sort_rst(sort_rst), .sort_en(sort_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic check_v(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic fill_words(input int vals);
    logic [DW-1:0] short_list[5];
    short_list = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd5};
    for (int i = 0; i < NW; i++) begin
      case (vals)
        0:       words[i] = DW'(100 + i);
        2:       words[i] = (i < 5) ? short_list[i] : 16'hFFFF;
        3:       words[i] = 16'h0001;
        default: words[i] = DW'($urandom);
      endcase
    end
  endtask

  // Runs one batch from IDLE or DONE and checks the full load/clear/sort/done sequence
  task automatic run_batch(input int n, input bit use_last, input int gap,
                           input int ign_start, input int exp_rst, input int exp_en);
    logic [DW-1:0] acc_q[$];
    logic [AW-1:0] exp_arr;
    int  k, cyc, rst_cnt, en_cnt, first_en, rst_at;
    bit  v, frozen_ok, ready_ok, busy_ok, prev_en;
    acc_q = {};
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check_i("ready_after_start", int'(in_ready), 1);
    check_i("busy_in_load", int'(busy), 1);
    check_i("done_dropped", int'(done), 0);
    check_v("array_cleared", array_out, '0);

    k = 0; cyc = 0;
    while (k < n && cyc < 4000) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = words[k];
      in_last  = use_last && (k == n - 1);
      if (v && in_ready) begin
        acc_q.push_back(words[k]);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check_i("accept_count", k, n);
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b0;

    exp_arr = '0;
    foreach (acc_q[i]) exp_arr[i*DW +: DW] = acc_q[i];

    rst_cnt = 0; en_cnt = 0; first_en = -1; rst_at = -1;
    frozen_ok = 1'b1; ready_ok = 1'b1; busy_ok = 1'b1; prev_en = 1'b0;
    for (cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (sort_rst) begin rst_cnt++; if (rst_at < 0) rst_at = cyc; end
      if (sort_en) begin en_cnt++; if (first_en < 0) first_en = cyc; end
      if (in_ready) ready_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (array_out !== exp_arr) frozen_ok = 1'b0;
      start   = (ign_start >= 0 && en_cnt == ign_start && sort_en);
      prev_en = sort_en;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;

    check_i("sort_rst_latency", rst_at, 0);
    check_i("sort_rst_cycles", rst_cnt, exp_rst);
    check_i("sort_en_latency", first_en, 1);
    check_i("sort_en_cycles", en_cnt, exp_en);
    check_i("done_latency", cyc, exp_en + 1);
    check_i("done_after_last_en", int'(prev_en), 1);
    check_i("done_high", int'(done), 1);
    check_i("sort_en_low_in_done", int'(sort_en), 0);
    check_i("busy_low_in_done", int'(busy), 0);
    check_i("no_ready_after_load", int'(ready_okay(ready_ok)), 1);
    check_i("busy_through_sort", int'(busy_ok), 1);
    check_i("array_frozen", int'(frozen_ok), 1);
    check_v("array_contents", array_out, exp_arr);
    @(negedge clk);
    check_i("done_held", int'(done), 1);
    check_v("array_held", array_out, exp_arr);
  endtask

  function automatic bit ready_okay(input bit ok);
    return ok;
  endfunction

  initial begin
    int cnt, guard;

    tbl[0] = '{32, 1'b0, 0, 0, -1, 1, SC};
    tbl[1] = '{32, 1'b0, 1, 1, 50, 1, SC};
    tbl[2] = '{ 5, 1'b1, 0, 2, -1, 1, SC};
    tbl[3] = '{32, 1'b0, 0, 3, -1, 1, SC};

    // Reset state
    repeat (2) @(negedge clk);
    check_i("reset_in_ready", int'(in_ready), 0);
    check_i("reset_busy", int'(busy), 0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_sort_en", int'(sort_en), 0);
    check_i("reset_sort_rst", int'(sort_rst), 0);
    check_v("reset_array", array_out, '0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234;
    repeat (2) @(negedge clk);
    check_i("idle_no_ready", int'(in_ready), 0);
    in_valid = 1'b0;

    for (int t = 0; t < 4; t++) begin
      fill_words(tbl[t].vals);
      run_batch(tbl[t].n, tbl[t].last, tbl[t].gap, tbl[t].ign_start, tbl[t].exp_rst, tbl[t].exp_en);
    end

    for (int r = 0; r < 6; r++) begin
      int  n;
      bit  last;
      n    = $urandom_range(1, NW);
      last = (n < NW) ? 1'b1 : 1'($urandom_range(0, 1));
      fill_words(1);
      run_batch(n, last, 2, -1, 1, SC);
    end

    // Mid-sort asynchronous reset
    fill_words(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = words[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    cnt = 0; guard = 0;
    while (cnt < 100 && guard < 400) begin
      if (sort_en) cnt++;
      if (cnt < 100) @(negedge clk);
      guard++;
    end
    check_i("reach_sort_cycle_100", cnt, 100);
    #2 rst_n = 1'b0;
    #1;
    check_v("async_rst_array", array_out, '0);
    check_i("async_rst_sort_en", int'(sort_en), 0);
    check_i("async_rst_busy", int'(busy), 0);
    check_i("async_rst_others", int'({in_ready, sort_rst, done}), 0);
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_i("post_rst_no_ready", int'(in_ready), 0);
      check_i("post_rst_idle", int'({busy, done, sort_en}), 0);
    end
    in_valid = 1'b0;
    fill_words(3);
    run_batch(NW, 1'b0, 0, -1, 1, SC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
